// File: rtl/vend_dispense_ctrl_if.sv
// vend_dispense_ctrl_if: vend code, sensor and mechanism-drive bundle for vend_dispense_ctrl
// Signals: Y (2-bit vend code), drop_sense, fault_clr driven by master;
//          motor_on, change_eject, vend_done, fault, q_overflow, code_err, q_count, busy driven by slave.
interface vend_dispense_ctrl_if #(
    parameter int QDEPTH = 4
);
    logic [1:0]              Y;
    logic                    drop_sense;
    logic                    fault_clr;
    logic                    motor_on;
    logic                    change_eject;
    logic                    vend_done;
    logic                    fault;
    logic                    q_overflow;
    logic                    code_err;
    logic [$clog2(QDEPTH):0] q_count;
    logic                    busy;
    modport master (
        output Y, drop_sense, fault_clr,
        input  motor_on, change_eject, vend_done, fault, q_overflow, code_err, q_count, busy
    );
    modport slave (
        input  Y, drop_sense, fault_clr,
        output motor_on, change_eject, vend_done, fault, q_overflow, code_err, q_count, busy
    );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: queues vend codes and sequences the product motor, drop check and change ejector
// Ports: clk (rising edge), rst_n (async active-low),
//        bus (slave): Y, drop_sense, fault_clr in; motor_on, change_eject, vend_done, fault,
//                     q_overflow, code_err, q_count, busy out.
module vend_dispense_ctrl #(
    parameter int MOTOR_CYC   = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int CHANGE_CYC  = 4,
    parameter int QDEPTH      = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    vend_dispense_ctrl_if.slave bus
);
    localparam int MC   = MOTOR_CYC > CHANGE_CYC ? MOTOR_CYC : CHANGE_CYC;
    localparam int MAXC = MC > TIMEOUT_CYC ? MC : TIMEOUT_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int PW   = $clog2(QDEPTH);
    localparam int NW   = PW + 1;
    typedef enum logic [2:0] {IDLE, MOTOR, WAIT_DROP, CHANGE, FAULT} state_t;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_drop, r_chg, r_motor, r_eject, r_done, r_fault, r_ovf, r_cerr;
    logic          r_mem [QDEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [NW-1:0] r_count;
    logic          w_push, w_pop, w_full, w_acc, w_dropped;
    logic [CW-1:0] w_cnt_inc;
    always_comb begin
        w_push    = bus.Y[1];
        w_pop     = r_state == IDLE && r_count != '0;
        w_full    = r_count == NW'(QDEPTH);
        // a pop in the same cycle frees the slot, so a full queue still accepts
        w_acc     = w_push && (!w_full || w_pop);
        w_dropped = r_drop || bus.drop_sense;
        w_cnt_inc = &r_cnt ? r_cnt : r_cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_cerr  <= 1'b0;
        end else begin
            if (w_acc) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + NW'(w_acc) - NW'(w_pop);
            r_ovf   <= w_push && !w_acc;
            r_cerr  <= bus.Y == 2'b01;
        end
    end
    always_ff @(posedge clk) begin
        if (w_acc) r_mem[r_wp] <= bus.Y[0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
            r_chg   <= 1'b0;
            r_motor <= 1'b0;
            r_eject <= 1'b0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_pop) begin
                    r_state <= MOTOR;
                    r_chg   <= r_mem[r_rp];
                    r_drop  <= 1'b0;
                    r_cnt   <= '0;
                    r_motor <= 1'b1;
                end
                MOTOR: begin
                    if (bus.drop_sense) r_drop <= 1'b1;
                    if (r_cnt == CW'(MOTOR_CYC - 1)) begin
                        r_state <= WAIT_DROP;
                        r_motor <= 1'b0;
                        r_cnt   <= '0;
                    end else r_cnt <= w_cnt_inc;
                end
                // drop is tested before the timeout so a drop on the last cycle still succeeds
                WAIT_DROP: if (w_dropped) begin
                    r_cnt <= '0;
                    if (r_chg) begin
                        r_state <= CHANGE;
                        r_eject <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    r_state <= FAULT;
                    r_fault <= 1'b1;
                    r_cnt   <= '0;
                end else r_cnt <= w_cnt_inc;
                CHANGE: if (r_cnt == CW'(CHANGE_CYC - 1)) begin
                    r_state <= IDLE;
                    r_eject <= 1'b0;
                    r_done  <= 1'b1;
                    r_cnt   <= '0;
                end else r_cnt <= w_cnt_inc;
                FAULT: if (bus.fault_clr) begin
                    r_state <= IDLE;
                    r_fault <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.motor_on     = r_motor;
    assign bus.change_eject = r_eject;
    assign bus.vend_done    = r_done;
    assign bus.fault        = r_fault;
    assign bus.q_overflow   = r_ovf;
    assign bus.code_err     = r_cerr;
    assign bus.q_count      = r_count;
    assign bus.busy         = r_state != IDLE || r_count != '0;
endmodule
